muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle multiply/divide unit with HI/LO registers, in the EX stage beside the ALU. It consumes the 4-bit `MULDIVMode` and HI/LO select that the decoder emits. It returns `start`/`busy` to the hazard controller, which stalls any ID-stage mul/div-class instruction while either is high. Reads of HI/LO (`mfhi`/`mflo`) are served from the architectural registers.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`; legal range 1..15.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `mode` input 4: operation select. 0 = NOTHING, 1 = MULT, 2 = MULTU, 3 = DIV, 4 = DIVU, 5 = MTHI, 6 = MTLO. Values 7..15 are treated as NOTHING.
- `rs_val` input 32: forwarded rs operand.
- `rt_val` input 32: forwarded rt operand.
- `hilo_sel` input 1: read select. 1 = HI, 0 = LO.
- `cancel` input 1: EX instruction is being flushed by an exception or interrupt. Suppresses any launch or HI/LO write this cycle.
- `start` output 1: combinational. Asserted when a multiply/divide launches this cycle.
- `busy` output 1: registered. High while an operation is in flight.
- `hilo_out` output 32: combinational read of HI or LO, per `hilo_sel`.

## Operation
- States: IDLE and BUSY, plus a down-counter `cnt` and pending registers `hi_nxt`/`lo_nxt`.
- Launch:
  - `start = (mode in {1..4}) & ~busy & ~cancel`.
  - When `start` is high, the result is computed from `rs_val`/`rt_val`, captured into `hi_nxt`/`lo_nxt`, `cnt` is loaded with the latency, and the state goes to BUSY.
- MULT: signed 32x32 product into 64 bits; HI = [63:32], LO = [31:0].
- MULTU: same split, unsigned product.
- DIV: signed; LO = quotient truncated toward zero, HI = remainder with the dividend's sign. 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- DIVU: unsigned; LO = quotient, HI = remainder.
- Divide by zero: see Configuration.
- BUSY:
  - `cnt` decrements each cycle.
  - On the edge where `cnt` reaches 1: HI ← `hi_nxt`, LO ← `lo_nxt`, `busy` clears, state returns to IDLE.
- MTHI/MTLO:
  - When `mode` is 5 or 6, `~cancel` and `~busy`, HI (or LO) ← `rs_val` at the clock edge.
  - If it arrives while busy, it is ignored. The hazard controller guarantees this never happens.
- New mul/div `mode` while busy: ignored, `start` stays 0. `busy` does not retrigger.
- `cancel` never aborts an in-flight operation. The launching instruction has already retired past EX, so it completes and commits.
- `hilo_out` always shows committed HI/LO. Pending results are never visible.
- Reset (asynchronous, any time including mid-operation):
  - HI = LO = 0, `hi_nxt` = `lo_nxt` = 0, `cnt` = 0, `busy` = 0, state IDLE.
  - `start` then depends on inputs only.

## Timing
- Launch in cycle T: `start` = 1 in T only. `busy` = 1 from T+1 through T+L, where L is `MULT_CYCLES` or `DIV_CYCLES`.
- HI/LO update at the edge closing T+L. `busy` = 0 and the new `hilo_out` are visible from T+L+1.
- Back-to-back launch is legal at T+L+1. The stall logic sees `start|busy` for L+1 consecutive cycles.
- MTHI/MTLO in cycle T: new value on `hilo_out` from T+1. No `start`, no `busy`.
- `hilo_out` has zero latency (combinational from registers).

## Configuration
- `MULDIV_DIVZERO_HOLD_EN` defined: divide with `rt_val` == 0 still runs the full `DIV_CYCLES` busy window, but commits nothing; HI/LO keep their prior values.
- Not defined: divide by zero commits HI = `rs_val`, LO = 0xFFFFFFFF for both DIV and DIVU.

## Structure
- Package `muldiv_pkg` holds:
  - mode constants MD_NOTHING..MD_MTLO, matching the decoder's encoding;
  - default latency constants;
  - the state enum (IDLE, BUSY).
- One sub-module, `muldiv_arith`: purely combinational. Takes `mode`, `rs_val`, `rt_val`; produces `hi_res`/`lo_res`, including the divide-by-zero and overflow rules.
- Counter, state machine and HI/LO registers live in `muldiv_unit`.

## Test plan
- MULT: rs = 0xFFFFFFFE, rt = 3 → `start` = 1 for 1 cycle, `busy` = 1 for 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. With MULTU: HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV: rs = 0xFFFFFFF9 (−7), rt = 2 → after 10 busy cycles LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU: 7 / 2 → LO = 3, HI = 1.
- MTHI 0x12345678, then MTLO 0xCAFEBABE on the next cycle → `hilo_sel` = 1 reads 0x12345678 and `hilo_sel` = 0 reads 0xCAFEBABE, each from the cycle after its write. `busy` stays 0.
- MULT launched, then MULT and MTLO held on `mode` during busy → second op ignored, `start` = 0 throughout, HI/LO hold the first result only.
- `cancel` = 1 with `mode` = DIV → `start` = 0, `busy` stays 0, HI/LO unchanged. `cancel` pulse at busy cycle 3 of a MULT → result still commits on schedule.
- `rst_n` low at busy cycle 2 of a DIV → `busy` = 0 and HI = LO = 0 immediately. No commit after `rst_n` rises. Also cover a divide by 0 with the macro both defined and undefined.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the multiply/divide unit: decoder mode
// encoding, default latencies and the IDLE/BUSY state type.
package muldiv_pkg;

  localparam logic [3:0] MD_NOTHING = 4'd0;
  localparam logic [3:0] MD_MULT    = 4'd1;
  localparam logic [3:0] MD_MULTU   = 4'd2;
  localparam logic [3:0] MD_DIV     = 4'd3;
  localparam logic [3:0] MD_DIVU    = 4'd4;
  localparam logic [3:0] MD_MTHI    = 4'd5;
  localparam logic [3:0] MD_MTLO    = 4'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] m);
    return (m >= MD_MULT) && (m <= MD_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] m);
    return (m == MD_DIV) || (m == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage bundle between the pipeline and the multiply/divide unit.
// Handshake: start is a single-cycle launch pulse; while start or busy is high the
// hazard controller holds any further mul/div-class instruction in ID.
interface muldiv_if;
  logic [3:0]  mode;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hilo_sel;
  logic        cancel;
  logic        start;
  logic        busy;
  logic [31:0] hilo_out;

  modport master (
    output mode, rs_val, rt_val, hilo_sel, cancel,
    input  start, busy, hilo_out
  );

  modport slave (
    input  mode, rs_val, rt_val, hilo_sel, cancel,
    output start, busy, hilo_out
  );
endinterface

// File: rtl/muldiv_arith.sv
// Combinational datapath: 32x32 products and 32/32 divides, including the
// divide-by-zero result and the signed-overflow case.
module muldiv_arith
  import muldiv_pkg::*;
(
  input  logic [3:0]  mode,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] div_b;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq;
  logic [31:0] sr;

  always_comb begin
    // Low 64 bits of a sign-extended product equal the signed product.
    prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // One unsigned divider serves both; signed divide works on magnitudes.
    // 0x80000000 / -1 falls out naturally: |a| = 0x80000000, negated back to itself.
    neg_a = (mode == MD_DIV) & rs_val[31];
    neg_b = (mode == MD_DIV) & rt_val[31];
    abs_a = neg_a ? -rs_val : rs_val;
    abs_b = neg_b ? -rt_val : rt_val;
    div_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
    uq    = abs_a / div_b;
    ur    = abs_a % div_b;
    sq    = (neg_a ^ neg_b) ? -uq : uq;
    sr    = neg_a ? -ur : ur;

    hi_res = 32'd0;
    lo_res = 32'd0;
    case (mode)
      MD_MULT:  {hi_res, lo_res} = prod_s;
      MD_MULTU: {hi_res, lo_res} = prod_u;
      MD_DIV, MD_DIVU: begin
        if (rt_val == 32'd0) begin
          hi_res = rs_val;
          lo_res = 32'hFFFF_FFFF;
        end else begin
          hi_res = sr;
          lo_res = sq;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional MULDIV_DIVZERO_HOLD_EN: divide by zero keeps the busy window but commits nothing.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus,
  output state_t   fsm_state
);

  localparam logic [3:0] MULT_L = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_L  = 4'(DIV_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic        busy_q;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] hi_nxt;
  logic [31:0] lo_nxt;
  logic        skip_q;
  logic [31:0] hi_res;
  logic [31:0] lo_res;
  logic        start;
  logic        mt_ok;
  logic        div_zero_hold;

  muldiv_arith u_arith (
    .mode   (bus.mode),
    .rs_val (bus.rs_val),
    .rt_val (bus.rt_val),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

`ifdef MULDIV_DIVZERO_HOLD_EN
  assign div_zero_hold = is_div(bus.mode) && (bus.rt_val == 32'd0);
`else
  assign div_zero_hold = 1'b0;
`endif

  assign start        = is_muldiv(bus.mode) & ~busy_q & ~bus.cancel;
  assign mt_ok        = ~busy_q & ~bus.cancel;
  assign bus.start    = start;
  assign bus.busy     = busy_q;
  assign bus.hilo_out = bus.hilo_sel ? hi : lo;
  assign fsm_state    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      busy_q <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      hi_nxt <= 32'd0;
      lo_nxt <= 32'd0;
      skip_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            hi_nxt <= hi_res;
            lo_nxt <= lo_res;
            skip_q <= div_zero_hold;
            cnt    <= is_div(bus.mode) ? DIV_L : MULT_L;
            busy_q <= 1'b1;
            state  <= BUSY;
          end else if (mt_ok && bus.mode == MD_MTHI) begin
            hi <= bus.rs_val;
          end else if (mt_ok && bus.mode == MD_MTLO) begin
            lo <= bus.rs_val;
          end
        end
        BUSY: begin
          // Inputs are ignored here; cancel cannot abort a retired launch.
          if (cnt == 4'd1) begin
            if (!skip_q) begin
              hi <= hi_nxt;
              lo <= lo_nxt;
            end
            cnt    <= 4'd0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed plan cases plus randomized
// operations against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int ML = MULT_CYCLES_DEF;
  localparam int DL = DIV_CYCLES_DEF;

  logic   clk = 1'b0;
  logic   rst_n = 1'b1;
  state_t fsm_state;

  muldiv_if bus();

  muldiv_unit #(.MULT_CYCLES(ML), .DIV_CYCLES(DL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;
  logic [63:0] exp_q[$];

  // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
  task automatic model(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                       output logic commit, output logic [31:0] hi, output logic [31:0] lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, up;
    commit = 1'b1;
    hi = exp_hi;
    lo = exp_lo;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (m == MD_MULT) begin
      q = sa * sb;
      {hi, lo} = q;
    end else if (m == MD_MULTU) begin
      up = ua * ub;
      {hi, lo} = up;
    end else if (b == 32'd0) begin
`ifdef MULDIV_DIVZERO_HOLD_EN
      commit = 1'b0;
`else
      hi = a;
      lo = 32'hFFFF_FFFF;
`endif
    end else if (m == MD_DIV) begin
      q = sa / sb;
      r = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end else begin
      up = ua / ub;
      lo = up[31:0];
      up = ua % ub;
      hi = up[31:0];
    end
  endtask

  // Launch one mul/div, watch its busy window, then check the commit.
  // now=1 launches in the current cycle (back-to-back after a previous do_op).
  task automatic do_op(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] busy_mode, input int cancel_at, input bit now);
    logic        commit;
    logic [31:0] nh, nl;
    logic [63:0] e;
    int          lat;
    if (!now) @(negedge clk);
    bus.mode = m; bus.rs_val = a; bus.rt_val = b; bus.cancel = 1'b0;
    #1;
    checks++;
    if (bus.start !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL launch mode=%0d start=%b busy=%b required start=1 busy=0", m, bus.start, bus.busy);
    end
    model(m, a, b, commit, nh, nl);
    exp_q.push_back(commit ? {nh, nl} : {exp_hi, exp_lo});
    lat = is_div(m) ? DL : ML;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      bus.mode = busy_mode; bus.rs_val = $urandom; bus.rt_val = $urandom;
      bus.cancel = (k == cancel_at); bus.hilo_sel = k[0];
      #1;
      checks++;
      if (bus.busy !== 1'b1 || bus.start !== 1'b0 || bus.hilo_out !== (k[0] ? exp_hi : exp_lo)) begin
        errors++;
        $display("FAIL busy_window cyc=%0d busy=%b start=%b hilo=%h required busy=1 start=0 hilo=%h",
                 k, bus.busy, bus.start, bus.hilo_out, k[0] ? exp_hi : exp_lo);
      end
    end
    @(negedge clk);
    bus.mode = MD_NOTHING; bus.cancel = 1'b0;
    #1;
    e = exp_q.pop_front();
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_end mode=%0d busy=%b required 0", m, bus.busy);
    end
    bus.hilo_sel = 1'b1; #1;
    checks++;
    if (bus.hilo_out !== exp_hi) begin
      errors++;
      $display("FAIL commit_hi mode=%0d a=%h b=%h got=%h required=%h", m, a, b, bus.hilo_out, exp_hi);
    end
    bus.hilo_sel = 1'b0; #1;
    checks++;
    if (bus.hilo_out !== exp_lo) begin
      errors++;
      $display("FAIL commit_lo mode=%0d a=%h b=%h got=%h required=%h", m, a, b, bus.hilo_out, exp_lo);
    end
  endtask

  task automatic do_mt(input logic [3:0] m, input logic [31:0] v);
    @(negedge clk);
    bus.mode = m; bus.rs_val = v; bus.cancel = 1'b0;
    #1;
    checks++;
    if (bus.start !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mt_no_start start=%b busy=%b required 0 0", bus.start, bus.busy);
    end
    if (m == MD_MTHI) exp_hi = v;
    else exp_lo = v;
  endtask

  task automatic test_reset();
    bus.mode = MD_MULT; bus.rs_val = 32'd0; bus.rt_val = 32'd0;
    bus.hilo_sel = 1'b0; bus.cancel = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || fsm_state !== IDLE || bus.start !== 1'b1) begin
      errors++;
      $display("FAIL reset_state busy=%b state=%0d start=%b required 0 0 1", bus.busy, fsm_state, bus.start);
    end
    bus.hilo_sel = 1'b1; #1;
    checks++;
    if (bus.hilo_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_hi got=%h required=0", bus.hilo_out);
    end
    bus.hilo_sel = 1'b0; bus.mode = MD_NOTHING; #1;
    checks++;
    if (bus.hilo_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_lo got=%h required=0", bus.hilo_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.hilo_out !== 32'd0) begin
      errors++;
      $display("FAIL post_reset busy=%b lo=%h required 0 0", bus.busy, bus.hilo_out);
    end
  endtask

  task automatic test_mult();
    do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, MD_NOTHING, 0, 1'b0);
    checks++;
    if (bus.hilo_out !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_lo_plan got=%h required=fffffffa", bus.hilo_out);
    end
    bus.hilo_sel = 1'b1; #1;
    checks++;
    if (bus.hilo_out !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL mult_hi_plan got=%h required=ffffffff", bus.hilo_out);
    end
    do_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, MD_NOTHING, 0, 1'b0);
    checks++;
    if (bus.hilo_out !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL multu_lo_plan got=%h required=fffffffa", bus.hilo_out);
    end
    bus.hilo_sel = 1'b1; #1;
    checks++;
    if (bus.hilo_out !== 32'h0000_0002) begin
      errors++;
      $display("FAIL multu_hi_plan got=%h required=00000002", bus.hilo_out);
    end
  endtask

  task automatic test_div();
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, MD_NOTHING, 0, 1'b0);
    checks++;
    if (bus.hilo_out !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_lo_plan got=%h required=fffffffd", bus.hilo_out);
    end
    bus.hilo_sel = 1'b1; #1;
    checks++;
    if (bus.hilo_out !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_hi_plan got=%h required=ffffffff", bus.hilo_out);
    end
    do_op(MD_DIVU, 32'd7, 32'd2, MD_NOTHING, 0, 1'b0);
    checks++;
    if (bus.hilo_out !== 32'd3) begin
      errors++;
      $display("FAIL divu_lo_plan got=%h required=3", bus.hilo_out);
    end
    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, MD_NOTHING, 0, 1'b0);
    checks++;
    if (bus.hilo_out !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_overflow_lo got=%h required=80000000", bus.hilo_out);
    end
  endtask

  task automatic test_mthilo();
    do_mt(MD_MTHI, 32'h1234_5678);
    do_mt(MD_MTLO, 32'hCAFE_BABE);
    bus.hilo_sel = 1'b1; #1;
    checks++;
    if (bus.hilo_out !== 32'h1234_5678 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi_read got=%h busy=%b required=12345678 0", bus.hilo_out, bus.busy);
    end
    @(negedge clk);
    bus.mode = MD_NOTHING; bus.hilo_sel = 1'b0; #1;
    checks++;
    if (bus.hilo_out !== 32'hCAFE_BABE || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo_read got=%h busy=%b required=cafebabe 0", bus.hilo_out, bus.busy);
    end
  endtask

  task automatic test_ignore_busy();
    do_op(MD_MULT, $urandom, $urandom, MD_MULT, 0, 1'b0);
    do_op(MD_MULT, $urandom, $urandom, MD_MTLO, 0, 1'b0);
    do_op(MD_DIVU, $urandom, $urandom_range(1, 1000), MD_MTHI, 0, 1'b0);
  endtask

  task automatic test_cancel();
    @(negedge clk);
    bus.mode = MD_DIV; bus.rs_val = 32'd100; bus.rt_val = 32'd5; bus.cancel = 1'b1;
    #1;
    checks++;
    if (bus.start !== 1'b0) begin
      errors++;
      $display("FAIL cancel_start got=%b required=0", bus.start);
    end
    @(negedge clk);
    bus.mode = MD_MTHI; bus.rs_val = 32'hDEAD_0001;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.start !== 1'b0) begin
      errors++;
      $display("FAIL cancel_busy busy=%b start=%b required 0 0", bus.busy, bus.start);
    end
    @(negedge clk);
    bus.mode = MD_NOTHING; bus.cancel = 1'b0; bus.hilo_sel = 1'b1;
    #1;
    checks++;
    if (bus.hilo_out !== exp_hi || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_hi got=%h busy=%b required=%h 0", bus.hilo_out, bus.busy, exp_hi);
    end
    do_op(MD_MULT, $urandom, $urandom, MD_NOTHING, 3, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    do_mt(MD_MTHI, 32'h5555_AAAA);
    do_mt(MD_MTLO, 32'h0F0F_F0F0);
    @(negedge clk);
    bus.mode = MD_DIV; bus.rs_val = 32'd1000; bus.rt_val = 32'd7;
    #1;
    checks++;
    if (bus.start !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_launch start=%b required=1", bus.start);
    end
    repeat (2) @(negedge clk);
    bus.mode = MD_NOTHING;
    #1 rst_n = 1'b0;
    #1;
    bus.hilo_sel = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.hilo_out !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_hi busy=%b hi=%h required 0 0", bus.busy, bus.hilo_out);
    end
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DL + 2) @(negedge clk);
    bus.hilo_sel = 1'b0; #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.hilo_out !== 32'd0) begin
      errors++;
      $display("FAIL rst_no_commit busy=%b lo=%h required 0 0", bus.busy, bus.hilo_out);
    end
  endtask

  task automatic test_div_zero();
    do_mt(MD_MTHI, 32'h1111_2222);
    do_mt(MD_MTLO, 32'h3333_4444);
    do_op(MD_DIV, 32'h8765_4321, 32'd0, MD_NOTHING, 0, 1'b0);
    do_op(MD_DIVU, 32'h0000_0042, 32'd0, MD_NOTHING, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_op(MD_MULTU, $urandom, $urandom, MD_NOTHING, 0, 1'b0);
    do_op(MD_DIV, $urandom, $urandom_range(1, 50), MD_NOTHING, 0, 1'b1);
    do_op(MD_MULT, $urandom, $urandom, MD_NOTHING, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [3:0]  m;
    logic [31:0] a, b;
    int          sel;
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 9);
        default: ;
      endcase
      if (sel < 4) begin
        m = 4'(sel + 1);
        do_op(m, a, b, 4'($urandom_range(0, 15)), $urandom_range(0, 4), 1'b0);
      end else if (sel < 6) begin
        do_mt((sel == 4) ? MD_MTHI : MD_MTLO, a);
      end else begin
        @(negedge clk);
        bus.mode = (sel == 6) ? MD_NOTHING : 4'($urandom_range(7, 15));
        bus.rs_val = a;
        #1;
        checks++;
        if (bus.start !== 1'b0 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL nop_mode mode=%0d start=%b busy=%b required 0 0", bus.mode, bus.start, bus.busy);
        end
      end
    end
    @(negedge clk);
    bus.mode = MD_NOTHING; bus.hilo_sel = 1'b1; #1;
    checks++;
    if (bus.hilo_out !== exp_hi) begin
      errors++;
      $display("FAIL random_final_hi got=%h required=%h", bus.hilo_out, exp_hi);
    end
    bus.hilo_sel = 1'b0; #1;
    checks++;
    if (bus.hilo_out !== exp_lo) begin
      errors++;
      $display("FAIL random_final_lo got=%h required=%h", bus.hilo_out, exp_lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthilo();
    test_ignore_busy();
    test_cancel();
    test_reset_mid_op();
    test_div_zero();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
